// File: rtl/div.sv
// Sequential signed divider, one quotient bit per clock.
// Restoring shift-subtract on magnitudes, then sign fix-up.
module div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             qsign;
    logic             rsign;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // One restoring step: shift {R,Q} left, trial-subtract M.
    always_comb begin
        r_sh  = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
        q_sh  = q << 1;
        t     = r_sh - {1'b0, m};
        a_mag = dividend[WIDTH-1] ? -dividend : dividend;
        b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    end

    // Control FSM with registered results and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            count    <= '0;
            r        <= '0;
            q        <= '0;
            m        <= '0;
            qsign    <= 1'b0;
            rsign    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            hi       <= dividend;
                            lo       <= '1;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            q        <= a_mag;
                            m        <= b_mag;
                            r        <= '0;
                            qsign    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rsign    <= dividend[WIDTH-1];
                            count    <= '0;
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!t[WIDTH]) begin
                        r <= t;
                        q <= q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        r <= r_sh;
                        q <= q_sh;
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= qsign ? -q : q;
                    hi    <= rsign ? -r[WIDTH-1:0] : r[WIDTH-1:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
